// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic              p1_err;

    logic [DATA_W-1:0] rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_err,
        output p1_gnt, p1_rvalid, p1_err,
        output rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_err,
        input  p1_gnt, p1_rvalid, p1_err,
        input  rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory between instruction fetch (port 0)
// and load/store (port 1); one access every two cycles, bad addresses never reach memory.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q;
    state_t            state_d;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic              sel;
    req_t              req_c;
    logic              bad_c;

    logic              last_gnt_q;
    logic              owner_q;
    logic              we_q;
    logic              bad_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              p0_rvalid_q;
    logic              p1_rvalid_q;
    logic              p0_err_q;
    logic              p1_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration: single requester wins; on a tie the port that did not win last time
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        sel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.p0_req && (!bus.p1_req || last_gnt_q)) begin
                    gnt0    = 1'b1;
                    sel     = 1'b0;
                    state_d = ACCESS;
                end else if (bus.p1_req) begin
                    gnt1    = 1'b1;
                    sel     = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = gnt0 || gnt1;

    // Winning request payload and its address legality
    always_comb begin
        if (sel) begin
            req_c = '{we: bus.p1_we, addr: bus.p1_addr, wdata: bus.p1_wdata};
        end else begin
            req_c = '{we: bus.p0_we, addr: bus.p0_addr, wdata: bus.p0_wdata};
        end
        bad_c = (req_c.addr[1:0] != 2'b00) || (req_c.addr > LAST_ADDR);
    end

    // Datapath: latch on accept, respond at the edge that ends ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q  <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            if (accept) begin
                owner_q     <= sel;
                last_gnt_q  <= sel;
                we_q        <= req_c.we;
                bad_q       <= bad_c;
                mem_addr_q  <= req_c.addr;
                mem_wdata_q <= req_c.wdata;
                mem_we_q    <= req_c.we && !bad_c;
            end
            if (state_q == ACCESS) begin
                rdata_q     <= (we_q || bad_q) ? '0 : bus.mem_rdata;
                p0_rvalid_q <= !owner_q;
                p1_rvalid_q <= owner_q;
                p0_err_q    <= !owner_q && bad_q;
                p1_err_q    <= owner_q && bad_q;
                mem_we_q    <= 1'b0;
            end
        end
    end

    // Grants are forced low while reset is asserted
    assign bus.p0_gnt    = gnt0 && rst_n;
    assign bus.p1_gnt    = gnt1 && rst_n;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_err    = p0_err_q;
    assign bus.p1_err    = p1_err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a negedge monitor scores every accepted request
// against a shadow memory and checks response port, error, data and cycle.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        p_req   [2];
    logic        p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] tbmem   [256];
    logic [31:0] shadow  [256];

    item_t q[$];
    int    glog[$];
    int    rlog[$];
    int    cyc;
    int    mwe_cnt;
    int    passed;
    int    total;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.p0_req   = p_req[0];
    assign bus.p0_we    = p_we[0];
    assign bus.p0_addr  = p_addr[0];
    assign bus.p0_wdata = p_wdata[0];
    assign bus.p1_req   = p_req[1];
    assign bus.p1_we    = p_we[1];
    assign bus.p1_addr  = p_addr[1];
    assign bus.p1_wdata = p_wdata[1];

    // Attached memory: combinational read, write on the rising edge
    assign bus.mem_rdata = (bus.mem_addr < 32'd1024) ? tbmem[bus.mem_addr[9:2]] : 32'd0;
    always @(posedge clk) begin
        if (bus.mem_we) tbmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic push_req(input int p);
        item_t       it;
        logic [31:0] a;
        a        = p_addr[p];
        it.port  = p;
        it.we    = p_we[p];
        it.addr  = a;
        it.wdata = p_wdata[p];
        it.err   = (a[1:0] != 2'b00) || (a > 32'd1020);
        it.rdata = (it.we || it.err) ? 32'd0 : shadow[a[9:2]];
        it.due   = cyc + 2;
        q.push_back(it);
        glog.push_back(p);
    endtask

    // Monitor: responses, accepts, grant exclusivity, write-enable activity
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_excl", 64'(bus.p0_gnt && bus.p1_gnt), 64'd0);
            if (bus.mem_we) mwe_cnt++;
            if (q.size() > 0 && cyc > q[0].due) begin
                check("resp_timeout", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            if (bus.p0_rvalid || bus.p1_rvalid) begin
                check("rvalid_onehot", 64'(bus.p0_rvalid && bus.p1_rvalid), 64'd0);
                if (q.size() == 0) begin
                    check("rvalid_unexpected", 64'd1, 64'd0);
                end else begin
                    item_t it;
                    it = q.pop_front();
                    check("resp_port", 64'(bus.p1_rvalid ? 1 : 0), 64'(it.port));
                    check("resp_err", 64'(bus.p1_rvalid ? bus.p1_err : bus.p0_err), 64'(it.err));
                    check("resp_rdata", 64'(bus.rdata), 64'(it.rdata));
                    check("resp_cycle", 64'(cyc), 64'(it.due));
                    if (it.we && !it.err) shadow[it.addr[9:2]] = it.wdata;
                    rlog.push_back(cyc);
                end
            end
            if (p_req[0] && bus.p0_gnt) push_req(0);
            if (p_req[1] && bus.p1_gnt) push_req(1);
        end
    end

    // Hold a request until n transfers have been accepted, then drop it
    task automatic drive_port(input int p, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int n);
        int cnt;
        int guard;
        @(posedge clk);
        #1;
        p_req[p]   = 1'b1;
        p_we[p]    = we;
        p_addr[p]  = addr;
        p_wdata[p] = wdata;
        cnt   = 0;
        guard = 0;
        while (cnt < n && guard < 40) begin
            @(negedge clk);
            guard++;
            if (rst_n && ((p == 0) ? bus.p0_gnt : bus.p1_gnt)) cnt++;
        end
        if (cnt < n) check("gnt_timeout", 64'(cnt), 64'(n));
        @(posedge clk);
        #1;
        p_req[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
        check({tag, "_rvalid"}, 64'({bus.p0_rvalid, bus.p1_rvalid}), 64'd0);
        check({tag, "_err"}, 64'({bus.p0_err, bus.p1_err}), 64'd0);
        check({tag, "_gnt"}, 64'({bus.p0_gnt, bus.p1_gnt}), 64'd0);
    endtask

    initial begin
        int exp_g[4];
        passed  = 0;
        total   = 0;
        cyc     = 0;
        mwe_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tbmem[i]  = 32'd0;
            shadow[i] = 32'd0;
        end
        tbmem[0]   = 32'h1111_1111; shadow[0]   = 32'h1111_1111;
        tbmem[2]   = 32'h2222_2222; shadow[2]   = 32'h2222_2222;
        tbmem[255] = 32'hA5A5_A5A5; shadow[255] = 32'hA5A5_A5A5;
        for (int p = 0; p < 2; p++) begin
            p_req[p]   = 1'b0;
            p_we[p]    = 1'b0;
            p_addr[p]  = 32'd0;
            p_wdata[p] = 32'd0;
        end

        // Reset values, grants gated while reset is low
        rst_n = 1'b0;
        #1;
        p_req[0] = 1'b1;
        #1;
        check_reset_outputs("por");
        p_req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Tie after reset: port 0 first, then port 1
        glog.delete();
        fork
            drive_port(0, 1'b0, 32'h0, 32'h0, 1);
            drive_port(1, 1'b0, 32'h8, 32'h0, 1);
            begin
                @(posedge clk);
                @(negedge clk);
                check("tie_first_gnt", 64'({bus.p0_gnt, bus.p1_gnt}), 64'b10);
            end
        join
        wait_drain();
        check("tie_gnt_count", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) begin
            check("tie_gnt0", 64'(glog[0]), 64'd0);
            check("tie_gnt1", 64'(glog[1]), 64'd1);
        end

        // Write then read on port 1
        drive_port(1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1);
        check("wr_access_mem_we", 64'(bus.mem_we), 64'd1);
        check("wr_access_mem_addr", 64'(bus.mem_addr), 64'h4);
        check("wr_access_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        wait_drain();
        drive_port(1, 1'b0, 32'h4, 32'h0, 1);
        wait_drain();

        // Sustained contention: alternating grants, responses every 2 cycles
        glog.delete();
        rlog.delete();
        fork
            drive_port(0, 1'b0, 32'h4, 32'h0, 2);
            drive_port(1, 1'b0, 32'h0, 32'h0, 2);
        join
        wait_drain();
        exp_g = '{0, 1, 0, 1};
        check("cont_gnt_count", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) check("cont_gnt_seq", 64'(glog[i]), 64'(exp_g[i]));
        end
        check("cont_resp_count", 64'(rlog.size()), 64'd4);
        if (rlog.size() == 4) begin
            for (int i = 1; i < 4; i++) check("cont_resp_spacing", 64'(rlog[i] - rlog[i-1]), 64'd2);
        end

        // Misaligned write never enables memory; data at 0x4 survives
        mwe_cnt = 0;
        drive_port(0, 1'b1, 32'h6, 32'h1234_5678, 1);
        check("mis_access_mem_we", 64'(bus.mem_we), 64'd0);
        wait_drain();
        check("mis_mem_we_count", 64'(mwe_cnt), 64'd0);
        drive_port(0, 1'b0, 32'h4, 32'h0, 1);
        wait_drain();

        // Out-of-range read and the last legal word
        mwe_cnt = 0;
        drive_port(1, 1'b0, 32'h400, 32'h0, 1);
        wait_drain();
        drive_port(1, 1'b0, 32'h3FC, 32'h0, 1);
        wait_drain();
        drive_port(0, 1'b1, 32'h8000_0010, 32'h5555_5555, 1);
        wait_drain();
        check("oor_mem_we_count", 64'(mwe_cnt), 64'd0);

        // Reset in the middle of a write's ACCESS cycle
        drive_port(0, 1'b1, 32'h10, 32'hCAFE_F00D, 1);
        #2;
        check("rst_pre_mem_we", 64'(bus.mem_we), 64'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        p_req[0] = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        p_req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive_port(0, 1'b0, 32'h10, 32'h0, 1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
